// File: rtl/if_stage_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b0;

  // CTRL stall vector layout
  localparam int STALL_W  = 6;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  // Source of the next PC, in descending priority
  typedef enum logic [2:0] {
    PC_SEL_BOOT,
    PC_SEL_FLUSH,
    PC_SEL_HOLD,
    PC_SEL_BRANCH,
    PC_SEL_SEQ
  } pc_sel_e;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   valid;
  } if_id_t;

  // Redirect targets are forced word-aligned; misaligned fetch is not trapped here.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register: chip-enable boot sequencing, next-PC priority mux and +4 adder.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic                   ce,
  output logic [INST_ADDR_W-1:0] pc
);

  pc_sel_e                pc_sel;
  logic [INST_ADDR_W-1:0] pc_next;

  // Choose the next-PC source; flush beats stall, stall masks a branch.
  always_comb begin
    // NOTE: default assigned first so every path drives pc_sel and no latch is inferred.
    pc_sel = PC_SEL_SEQ;
    if (ce == CHIP_DISABLE) begin
      pc_sel = PC_SEL_BOOT;
    end else if (flush) begin
      pc_sel = PC_SEL_FLUSH;
    end else if (hold) begin
      pc_sel = PC_SEL_HOLD;
    end else if (branch_flag) begin
      pc_sel = PC_SEL_BRANCH;
    end
  end

  // Next-PC data mux; the sequential path wraps naturally at 32 bits.
  always_comb begin
    pc_next = pc + PC_STEP;
    unique case (pc_sel)
      PC_SEL_BOOT:   pc_next = RESET_PC;
      PC_SEL_FLUSH:  pc_next = word_align(new_pc);
      PC_SEL_HOLD:   pc_next = pc;
      PC_SEL_BRANCH: pc_next = word_align(branch_target);
      PC_SEL_SEQ:    pc_next = pc + PC_STEP;
      default:       pc_next = pc + PC_STEP;
    endcase
  end

  // Chip enable goes high on the first clock after reset is released.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst == RST_ENABLE) begin
      ce <= CHIP_DISABLE;
    end else begin
      ce <= CHIP_ENABLE;
    end
  end

  // PC register; held at RESET_PC until the ROM is enabled.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives inst_rom and captures the fetched word into IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0]      rom_inst_i,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   id_valid_o
);

  if_id_t if_id_q;
  logic   bubble;
  logic   unused_stall;

  // Upper stall bits belong to later stages.
  assign unused_stall = ^stall[STALL_W-1:STALL_ID+1];

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .hold          (stall[STALL_PC]),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag_i),
    .branch_target (branch_target_i),
    .ce            (rom_ce_o),
    .pc            (rom_addr_o)
  );

  // IF stalled while ID moves on: ID must see an empty slot, not a repeat.
  assign bubble = stall[STALL_IF] && !stall[STALL_ID];

  // IF/ID register: flush or bubble clears, a full stall holds, otherwise capture the fetch.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush || bubble) begin
      if_id_q.pc    <= '0;
      if_id_q.inst  <= ZERO_WORD;
      if_id_q.valid <= 1'b0;
    end else if (stall[STALL_IF]) begin
      if_id_q <= if_id_q;
    end else begin
      if_id_q.pc    <= rom_addr_o;
      if_id_q.inst  <= (rom_ce_o == CHIP_ENABLE) ? rom_inst_i : ZERO_WORD;
      if_id_q.valid <= (rom_ce_o == CHIP_ENABLE);
    end
  end

  assign id_pc_o    = if_id_q.pc;
  assign id_inst_o  = if_id_q.inst;
  assign id_valid_o = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table driven through a scoreboard queue.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic        e_ce;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  // Instruction ROM contents: three known words, then an address-tagged pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h3401_0001;
      32'h4:   return 32'h3402_0002;
      32'h8:   return 32'h3403_0003;
      default: return {16'hA000, a[15:0]};
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic [5:0] s, input logic fl,
                              input logic [31:0] npc, input logic b, input logic [31:0] t,
                              input logic ece, input logic [31:0] eaddr, input logic [31:0] epc,
                              input logic [31:0] einst, input logic ev);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = fl; v.new_pc = npc; v.br = b; v.tgt = t;
    v.e_ce = ece; v.e_addr = eaddr; v.e_pc = epc; v.e_inst = einst; v.e_valid = ev;
    return v;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one vector at negedge, push its expectation, compare just after the posedge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; flush = v.flush; new_pc = v.new_pc;
    branch_flag_i = v.br; branch_target_i = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".ce"},    {31'b0, rom_ce_o},   {31'b0, e.e_ce});
      check({tag, ".addr"},  rom_addr_o,          e.e_addr);
      check({tag, ".id_pc"}, id_pc_o,             e.e_pc);
      check({tag, ".inst"},  id_inst_o,           e.e_inst);
      check({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, e.e_valid});
    end
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_i = '0;

    // Reset held three cycles, then boot and sequential fetch
    vecs.push_back(mk(0, 6'h00, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h4,  32'h0,  rom_word(32'h0), 1));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h8,  32'h4,  rom_word(32'h4), 1));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'hC,  32'h8,  rom_word(32'h8), 1));
    // Branch to misaligned 0x43 -> 0x40; delay slot at 0xC still enters ID
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  1, 32'h43,  1, 32'h40, 32'hC,  rom_word(32'hC), 1));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h44, 32'h40, rom_word(32'h40), 1));
    // stall=000011: PC holds, ID gets bubbles
    vecs.push_back(mk(1, 6'h03, 0, 32'h0,  0, 32'h0,   1, 32'h44, 32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h03, 0, 32'h0,  0, 32'h0,   1, 32'h44, 32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h48, 32'h44, rom_word(32'h44), 1));
    // stall=000111: everything holds; branch ignored while PC stalled
    vecs.push_back(mk(1, 6'h07, 0, 32'h0,  0, 32'h0,   1, 32'h48, 32'h44, rom_word(32'h44), 1));
    vecs.push_back(mk(1, 6'h07, 0, 32'h0,  1, 32'h100, 1, 32'h48, 32'h44, rom_word(32'h44), 1));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h4C, 32'h48, rom_word(32'h48), 1));
    // Flush over stall and branch
    vecs.push_back(mk(1, 6'h07, 1, 32'h20, 1, 32'h100, 1, 32'h20, 32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h24, 32'h20, rom_word(32'h20), 1));
    // Flush target alignment
    vecs.push_back(mk(1, 6'h00, 1, 32'h87, 0, 32'h0,   1, 32'h84, 32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h88, 32'h84, rom_word(32'h84), 1));
    // Wrap: branch to top word, then +4 wraps to 0
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 32'h88, rom_word(32'h88), 1));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h4,  32'h0,  rom_word(32'h0), 1));
    // Mid-run reset for one cycle, then reboot
    vecs.push_back(mk(0, 6'h00, 0, 32'h0,  0, 32'h0,   0, 32'h0,  32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h0,  32'h0,  32'h0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,  0, 32'h0,   1, 32'h4,  32'h0,  rom_word(32'h0), 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // stall=000110: PC advances while IF/ID holds
    step(mk(1, 6'h06, 0, 32'h0, 0, 32'h0, 1, 32'h8, 32'h0, rom_word(32'h0), 1), "h_ifhold");
    step(mk(1, 6'h00, 0, 32'h0, 0, 32'h0, 1, 32'hC, 32'h8, rom_word(32'h8), 1), "h_resume");
    // stall=000001: PC holds, IF/ID re-captures the same fetch; branch masked
    step(mk(1, 6'h01, 0, 32'h0, 0, 32'h0,   1, 32'hC, 32'hC, rom_word(32'hC), 1), "h_pchold0");
    step(mk(1, 6'h01, 0, 32'h0, 1, 32'h200, 1, 32'hC, 32'hC, rom_word(32'hC), 1), "h_pchold1");
    // Reset dominates flush and stall; flush during boot cannot move PC off RESET_PC
    step(mk(0, 6'h07, 1, 32'h50, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0), "h_rstflush");
    step(mk(1, 6'h00, 1, 32'h50, 0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0), "h_bootflush");
    step(mk(1, 6'h00, 0, 32'h0,  0, 32'h0, 1, 32'h4, 32'h0, rom_word(32'h0), 1), "h_reboot");

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
